// File: rtl/p09_debouncer.sv
// p09_debouncer: removes contact bounce from an already-synchronized level.
// Emits a registered debounced level, one-cycle rise/fall pulses and a
// one-cycle long-press pulse once the level has been held high long enough.
module p09_debouncer #(
    parameter int unsigned STABLE_CYCLES = 50000,
    parameter int unsigned LONG_CYCLES   = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES);
    // One extra code above LONG_CYCLES-1 so the counter can park there after firing.
    localparam int unsigned HW = $clog2(LONG_CYCLES + 1);

    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);

    typedef enum logic [1:0] {
        S_LOW,
        S_RISE_WAIT,
        S_HIGH,
        S_FALL_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] stab_q,  stab_d;
    logic [HW-1:0] hold_q,  hold_d;
    logic          out_q,   out_d;
    logic          rise_q,  rise_d;
    logic          fall_q,  fall_d;
    logic          lp_q,    lp_d;

    // State, counters and all outputs registered; reset forces the idle-low state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOW;
            stab_q  <= '0;
            hold_q  <= '0;
            out_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            lp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            lp_q    <= lp_d;
        end
    end

    // Debounce FSM, hold counter and pulse generation.
    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        out_d   = out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        hold_d  = hold_q;
        lp_d    = 1'b0;

        case (state_q)
            S_LOW: begin
                stab_d = '0;
                if (in) begin
                    state_d = S_RISE_WAIT;
                    stab_d  = SW'(1);
                end
            end
            S_RISE_WAIT: begin
                if (!in) begin
                    state_d = S_LOW;
                    stab_d  = '0;
                end else if (stab_q == STAB_LAST) begin
                    state_d = S_HIGH;
                    stab_d  = '0;
                    out_d   = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    stab_d = stab_q + SW'(1);
                end
            end
            S_HIGH: begin
                stab_d = '0;
                if (!in) begin
                    state_d = S_FALL_WAIT;
                    stab_d  = SW'(1);
                end
            end
            S_FALL_WAIT: begin
                if (in) begin
                    state_d = S_HIGH;
                    stab_d  = '0;
                end else if (stab_q == STAB_LAST) begin
                    state_d = S_LOW;
                    stab_d  = '0;
                    out_d   = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    stab_d = stab_q + SW'(1);
                end
            end
            default: begin
                state_d = S_LOW;
                stab_d  = '0;
                out_d   = 1'b0;
            end
        endcase

        // Hold counter counts edges with out high; firing moves it to the
        // saturation code so at most one long_press occurs per press.
        if (!out_q || fall_d) begin
            hold_d = '0;
        end else if (hold_q != HOLD_SAT) begin
            hold_d = hold_q + HW'(1);
        end

        // An accepted release on the same edge takes priority over long_press.
        lp_d = out_q && (hold_q == HOLD_LAST) && !fall_d;
    end

    assign out        = out_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign long_press = lp_q;

endmodule
